// File: rtl/cc_stream_loader.sv
// cc_stream_loader: nibble-serial front/back stage for the CC compute core.
// Assembles NUM_IN operands plus opt/equ from a valid/ready stream, presents
// them to CC as registered operands, captures CC's signed result one cycle
// later and returns it over a valid/ready handshake.
// Optional feature macro: BURST_ABORT_EN -- a gap while loading discards the
// burst and pulses out_abort; without it gaps simply stall.
module cc_stream_loader #(
    parameter int DATA_W = 4,
    parameter int NUM_IN = 6,
    parameter int RES_W  = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [2:0]               in_opt,
    input  logic                     in_equ,
    output logic [NUM_IN*DATA_W-1:0] cc_in_n,
    output logic [2:0]               cc_opt,
    output logic                     cc_equ,
    input  logic [RES_W-1:0]         cc_out_n,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [RES_W-1:0]         out_data,
    output logic                     out_abort
);

    localparam int CNT_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NUM_IN - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        EVAL,
        HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic             abort_d;

    // Next-state, beat counter and handshake decode.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path can infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        abort_d  = 1'b0;
        in_ready = (state_q == IDLE) || (state_q == LOAD);
        accept   = in_valid && in_ready;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (NUM_IN == 1) begin
                        state_d = EVAL;
                        cnt_d   = '0;
                    end else begin
                        state_d = LOAD;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    if (cnt_q == LAST_SLOT) begin
                        state_d = EVAL;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
`ifdef BURST_ABORT_EN
                    // A gap mid-burst drops the partial transaction.
                    state_d = IDLE;
                    cnt_d   = '0;
                    abort_d = 1'b1;
`endif
                end
            end
            EVAL:    state_d = HOLD;
            HOLD:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and beat-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Operand slots and opt/equ: written in place, so CC sees the previous
    // transaction's values until a new burst overwrites them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_in_n <= '0;
            cc_opt  <= '0;
            cc_equ  <= 1'b0;
        end else if (accept) begin
            if (state_q == IDLE) begin
                cc_in_n[DATA_W-1:0] <= in_data;
                cc_opt              <= in_opt;
                cc_equ              <= in_equ;
            end else begin
                cc_in_n[cnt_q*DATA_W +: DATA_W] <= in_data;
            end
        end
    end

    // Result capture at the end of EVAL; held until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (state_q == EVAL) begin
            out_data  <= cc_out_n;
            out_valid <= 1'b1;
        end else if (state_q == HOLD && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef BURST_ABORT_EN
    // One-cycle abort pulse following the gap that killed the burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_abort <= 1'b0;
        end else begin
            out_abort <= abort_d;
        end
    end
`else
    assign out_abort = 1'b0;
    logic unused_abort;
    assign unused_abort = abort_d;
`endif

endmodule

// File: tb/tb_cc_stream_loader.sv
// Directed self-checking bench for cc_stream_loader. A small combinational
// stand-in for CC drives cc_out_n; expected results are hand-computed.
module tb_cc_stream_loader;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_data;
    logic [2:0]  in_opt;
    logic        in_equ;
    logic [23:0] cc_in_n;
    logic [2:0]  cc_opt;
    logic        cc_equ;
    logic [9:0]  cc_out_n;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  out_data;
    logic        out_abort;

    int assertions;
    int failures;

    logic [3:0] beats [6];
    logic [2:0] opts  [6];
    int         ops   [6];

    cc_stream_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_opt    (in_opt),
        .in_equ    (in_equ),
        .cc_in_n   (cc_in_n),
        .cc_opt    (cc_opt),
        .cc_equ    (cc_equ),
        .cc_out_n  (cc_out_n),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_abort (out_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CC stand-in: opt[0] selects sum or (first three - last three); equ negates.
    function automatic int cc_calc(input int v[6], input logic [2:0] opt, input logic equ);
        int r;
        if (opt[0]) r = (v[0] + v[1] + v[2]) - (v[3] + v[4] + v[5]);
        else        r = v[0] + v[1] + v[2] + v[3] + v[4] + v[5];
        if (equ) r = -r;
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < 6; i++) ops[i] = int'(cc_in_n[i*4 +: 4]);
        cc_out_n = 10'(cc_calc(ops, cc_opt, cc_equ));
    end

    // Stream the first n beats of beats/opts; equ only valid on beat 0, the
    // rest carry ~equ. Optional idle gap inserted before beat gap_at.
    task automatic send_burst(input logic equ, input int n, input int gap_at, input int gap_len);
        int k;
        for (int i = 0; i < n; i++) begin
            if (i == gap_at && gap_len > 0) begin
                in_valid = 1'b0;
                repeat (gap_len) begin
                    @(posedge clk);
                    #1;
                end
            end
            in_valid = 1'b1;
            in_data  = beats[i];
            in_opt   = opts[i];
            in_equ   = (i == 0) ? equ : ~equ;
            k = 0;
            while (!in_ready && k < 20) begin
                @(posedge clk);
                #1;
                k++;
            end
            assertions++;
            if (k == 20) begin
                failures++;
                $display("FAIL in_ready_timeout beat=%0d in_ready=%b required=1", i, in_ready);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_opt    = '0;
        in_equ    = 1'b0;
        out_ready = 1'b0;
        #12;
        assertions++;
        if ({cc_in_n, cc_opt, cc_equ, out_data, out_valid, out_abort} !== '0) begin
            failures++;
            $display("FAIL reset_outputs cc_in_n=%h opt=%b equ=%b data=%h valid=%b abort=%b required all 0",
                     cc_in_n, cc_opt, cc_equ, out_data, out_valid, out_abort);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        assertions++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%b required=1", in_ready);
        end
    endtask

    task automatic test_back_to_back();
        beats     = '{4'h3, 4'h5, 4'h1, 4'h7, 4'h2, 4'h4};
        opts      = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
        out_ready = 1'b1;
        send_burst(1'b0, 6, -1, 0);
        // Now in EVAL: operands assembled, result not yet valid.
        assertions++;
        if (cc_in_n !== 24'h427153) begin
            failures++;
            $display("FAIL b2b_cc_in_n got=%h required=427153", cc_in_n);
        end
        assertions++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_eval_cycle out_valid=%b in_ready=%b required 0/0", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        assertions++;
        if (out_valid !== 1'b1 || out_data !== 10'd22) begin
            failures++;
            $display("FAIL b2b_result valid=%b data=%0d required valid=1 data=22", out_valid, out_data);
        end
        @(posedge clk);
        #1;
        assertions++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_handshake out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_signed();
        beats     = '{4'hF, 4'h8, 4'h1, 4'h0, 4'h2, 4'h7};
        opts      = '{3'b011, 3'b011, 3'b011, 3'b011, 3'b011, 3'b011};
        out_ready = 1'b1;
        send_burst(1'b1, 6, -1, 0);
        @(posedge clk);
        #1;
        // (15+8+1)-(0+2+7) = 15, negated by equ -> -15
        assertions++;
        if (out_valid !== 1'b1 || out_data !== 10'h3F1) begin
            failures++;
            $display("FAIL signed_result valid=%b data=%h required valid=1 data=3f1", out_valid, out_data);
        end
        assertions++;
        if (out_data[9] !== cc_out_n[9] || out_data[9] !== 1'b1) begin
            failures++;
            $display("FAIL signed_sign out_data[9]=%b cc_out_n[9]=%b required 1", out_data[9], cc_out_n[9]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        beats     = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
        opts      = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
        out_ready = 1'b0;
        send_burst(1'b0, 6, -1, 0);
        @(posedge clk);
        #1;
        assertions++;
        if (out_valid !== 1'b1 || out_data !== 10'd21) begin
            failures++;
            $display("FAIL bp_result valid=%b data=%0d required valid=1 data=21", out_valid, out_data);
        end
        in_valid = 1'b1;
        in_data  = 4'h9;
        in_opt   = 3'b111;
        in_equ   = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            assertions++;
            if (out_valid !== 1'b1 || out_data !== 10'd21 || in_ready !== 1'b0 || cc_in_n !== 24'h654321) begin
                failures++;
                $display("FAIL bp_hold cycle=%0d valid=%b data=%0d in_ready=%b cc_in_n=%h required 1/21/0/654321",
                         c, out_valid, out_data, in_ready, cc_in_n);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        assertions++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || cc_in_n !== 24'h654321 || cc_opt !== 3'b000) begin
            failures++;
            $display("FAIL bp_release valid=%b in_ready=%b cc_in_n=%h cc_opt=%b required 0/1/654321/000",
                     out_valid, in_ready, cc_in_n, cc_opt);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_gaps();
        int pulses;
        beats     = '{4'h3, 4'h5, 4'h1, 4'h7, 4'h2, 4'h4};
        opts      = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
        out_ready = 1'b1;
`ifdef BURST_ABORT_EN
        send_burst(1'b0, 2, -1, 0);
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            if (out_abort === 1'b1) pulses++;
            assertions++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL gap_abort_no_valid cycle=%0d out_valid=%b required=0", c, out_valid);
            end
        end
        assertions++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL gap_abort_pulses got=%0d required=1", pulses);
        end
        assertions++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL gap_abort_idle in_ready=%b required=1", in_ready);
        end
`else
        pulses = 0;
        send_burst(1'b0, 6, 2, 2);
        assertions++;
        if (cc_in_n !== 24'h427153) begin
            failures++;
            $display("FAIL gap_cc_in_n got=%h required=427153", cc_in_n);
        end
        @(posedge clk);
        #1;
        if (out_abort === 1'b1) pulses++;
        assertions++;
        if (out_valid !== 1'b1 || out_data !== 10'd22 || pulses != 0) begin
            failures++;
            $display("FAIL gap_result valid=%b data=%0d abort=%b required valid=1 data=22 abort=0",
                     out_valid, out_data, out_abort);
        end
        @(posedge clk);
        #1;
`endif
    endtask

    task automatic test_opt_sampling();
        beats     = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
        opts      = '{3'b101, 3'b001, 3'b010, 3'b011, 3'b100, 3'b110};
        out_ready = 1'b1;
        send_burst(1'b1, 6, -1, 0);
        assertions++;
        if (cc_opt !== 3'b101 || cc_equ !== 1'b1) begin
            failures++;
            $display("FAIL opt_sampling cc_opt=%b cc_equ=%b required 101/1", cc_opt, cc_equ);
        end
        @(posedge clk);
        #1;
        // (1+2+3)-(4+5+6) = -9, negated -> 9
        assertions++;
        if (out_valid !== 1'b1 || out_data !== 10'd9) begin
            failures++;
            $display("FAIL opt_result valid=%b data=%0d required valid=1 data=9", out_valid, out_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_burst();
        beats     = '{4'h7, 4'h7, 4'h7, 4'h7, 4'h7, 4'h7};
        opts      = '{3'b110, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
        out_ready = 1'b1;
        send_burst(1'b1, 3, -1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        assertions++;
        if ({cc_in_n, cc_opt, cc_equ, out_data, out_valid, out_abort} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs cc_in_n=%h opt=%b equ=%b data=%h valid=%b abort=%b required all 0",
                     cc_in_n, cc_opt, cc_equ, out_data, out_valid, out_abort);
        end
        #20;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        assertions++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midreset_in_ready got=%b required=1", in_ready);
        end
        beats = '{4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD};
        opts  = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
        send_burst(1'b0, 6, -1, 0);
        assertions++;
        if (cc_in_n !== 24'hDCBA98) begin
            failures++;
            $display("FAIL midreset_cc_in_n got=%h required=dcba98", cc_in_n);
        end
        @(posedge clk);
        #1;
        assertions++;
        if (out_valid !== 1'b1 || out_data !== 10'd63) begin
            failures++;
            $display("FAIL midreset_result valid=%b data=%0d required valid=1 data=63", out_valid, out_data);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        assertions = 0;
        failures   = 0;
        test_reset();
        test_back_to_back();
        test_signed();
        test_backpressure();
        test_gaps();
        test_opt_sampling();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
